// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int SERIAL_SUB_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_sub_fullsub.sv
// One-bit full subtractor built from xor2/nand2/inv cells, plus those cells.
// d = a ^ b ^ b_in ; b_out = (~a & b) | (~(a ^ b) & b_in), formed as a NAND-NAND sum of products.
module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module inv (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module fullSub_1b (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);
    logic ab_x, a_n, ab_xn, term_gen_n, term_prop_n;

    xor2  u_x0 (.a(a),     .b(b),     .y(ab_x));
    xor2  u_x1 (.a(ab_x),  .b(b_in),  .y(d));
    inv   u_i0 (.a(a),     .y(a_n));
    inv   u_i1 (.a(ab_x),  .y(ab_xn));
    nand2 u_n0 (.a(a_n),   .b(b),     .y(term_gen_n));
    nand2 u_n1 (.a(ab_xn), .b(b_in),  .y(term_prop_n));
    nand2 u_n2 (.a(term_gen_n), .b(term_prop_n), .y(b_out));
endmodule

// File: rtl/serial_sub.sv
// Bit-serial a-b, LSB first, one bit per cycle; optional signed overflow via SERIAL_SUB_OVF_EN.
// Latency WIDTH+1 cycles start->done; no backpressure, start is ignored while busy.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d, shift_val;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_a, bit_b, bit_d, bit_bout;

    // Operands stay parallel; the counter selects the bit under subtraction.
    assign bit_a     = a_q[cnt_q];
    assign bit_b     = b_q[cnt_q];
    assign shift_val = {bit_d, shadow_q[WIDTH-1:1]};

    fullSub_1b u_fullsub (
        .a     (bit_a),
        .b     (bit_b),
        .b_in  (brw_q),
        .d     (bit_d),
        .b_out (bit_bout)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        shadow_d     = shadow_q;
        diff_d       = diff_q;
        brw_d        = brw_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d        = ovf_q;
`endif
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d = SHIFT;
                    a_d     = a;
                    b_d     = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shadow_d = shift_val;
                brw_d    = bit_bout;
                if (cnt_q == CNT_LAST) begin
                    // Results become visible only here, never mid-operation.
                    state_d      = DONE;
                    cnt_d        = '0;
                    diff_d       = shift_val;
                    borrow_out_d = bit_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d        = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (bit_d != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            shadow_q     <= '0;
            diff_q       <= '0;
            brw_q        <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            shadow_q     <= shadow_d;
            diff_q       <= diff_d;
            brw_q        <= brw_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule
